// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and BCD digit type for the stopwatch front panel
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} sw_state_e;
    typedef logic [3:0] bcd_t;
    localparam int NUM_DIGITS = 6;
endpackage

// File: rtl/stopwatch_if.sv
// stopwatch_if: link between the panel controller (master) and the stopwatch counter (slave)
interface stopwatch_if;
    import stopwatch_pkg::*;
    bcd_t d5, d4, d3, d2, d1, d0;
    logic go, clr;
    modport master (input d5, d4, d3, d2, d1, d0, output go, clr);
    modport slave (output d5, d4, d3, d2, d1, d0, input go, clr);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes a raw button, accepts changes after DB_CYCLES stable cycles, pulses on press
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_stable,
    output logic press_pulse
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          pulse_q, pulse_d;
    logic          done;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        done     = (sync2_q != stable_q) && (cnt_q == CW'(DB_CYCLES - 1));
        cnt_d    = (sync2_q == stable_q || done) ? '0 : cnt_q + 1'b1;
        stable_d = done ? ~stable_q : stable_q;
        pulse_d  = done & ~stable_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
        end
    end
    assign btn_stable  = stable_q;
    assign press_pulse = pulse_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button debounce, start/stop/lap/reset FSM and live/lap display mux
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_ss,
    input  logic        btn_lr,
    stopwatch_if.master sw,
    output bcd_t        disp5,
    output bcd_t        disp4,
    output bcd_t        disp3,
    output bcd_t        disp2,
    output bcd_t        disp1,
    output bcd_t        disp0,
    output logic        lap_active,
    output logic [1:0]  state
);
    logic ss_pulse, lr_pulse, lr_only;
    sw_state_e state_q, state_d;
    logic go_q, go_d, clr_q, clr_d, lap_active_q, lap_active_d;
    bcd_t [NUM_DIGITS-1:0] live, lap_q, lap_d, disp_q, disp_d;
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk, .rst_n, .btn_raw(btn_ss), .btn_stable(), .press_pulse(ss_pulse)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lr (
        .clk, .rst_n, .btn_raw(btn_lr), .btn_stable(), .press_pulse(lr_pulse)
    );
    assign live = {sw.d5, sw.d4, sw.d3, sw.d2, sw.d1, sw.d0};
    // start/stop has priority: a lap/reset press in the same cycle is dropped
    always_comb begin
        lr_only = lr_pulse & ~ss_pulse;
        case (state_q)
            IDLE:    state_d = ss_pulse ? RUN : IDLE;
            RUN:     state_d = ss_pulse ? PAUSE : lr_only ? LAP : RUN;
            LAP:     state_d = ss_pulse ? PAUSE : lr_only ? RUN : LAP;
            default: state_d = ss_pulse ? RUN : lr_only ? IDLE : PAUSE;
        endcase
        go_d         = (state_d == RUN) || (state_d == LAP);
        clr_d        = (state_q == PAUSE) && (state_d == IDLE);
        lap_active_d = state_d == LAP;
        lap_d        = (state_q == RUN && state_d == LAP) ? live : lap_q;
        disp_d       = lap_active_d ? lap_d : live;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            go_q         <= 1'b0;
            clr_q        <= 1'b1;
            lap_active_q <= 1'b0;
            lap_q        <= '0;
            disp_q       <= '0;
        end else begin
            state_q      <= state_d;
            go_q         <= go_d;
            clr_q        <= clr_d;
            lap_active_q <= lap_active_d;
            lap_q        <= lap_d;
            disp_q       <= disp_d;
        end
    end
    assign sw.go      = go_q;
    assign sw.clr     = clr_q;
    assign lap_active = lap_active_q;
    assign state      = state_q;
    assign {disp5, disp4, disp3, disp2, disp1, disp0} = disp_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: vector table, hand-written corner sequences and randomized events against an event-level model
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, btn_ss = 1'b0, btn_lr = 1'b0;
    logic [23:0] dv = '0;
    bcd_t disp5, disp4, disp3, disp2, disp1, disp0;
    logic lap_active;
    logic [1:0] state;
    int pass_cnt = 0, total = 0, clr_cnt = 0, overlap = 0;
    stopwatch_if sw();
    assign {sw.d5, sw.d4, sw.d3, sw.d2, sw.d1, sw.d0} = dv;
    stopwatch_ctrl #(.DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lr(btn_lr), .sw(sw),
        .disp5(disp5), .disp4(disp4), .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
        .lap_active(lap_active), .state(state)
    );
    always #5 clk = ~clk;
    wire [23:0] disp_all = {disp5, disp4, disp3, disp2, disp1, disp0};
    typedef struct {
        bit ss; bit lr; logic [23:0] d;
        int st; bit go; bit lap; logic [23:0] disp; int clrs;
    } vec_t;
    vec_t vecs[13];
    // next state per press kind, indexed by the state code
    int nxt_ss[4] = '{1, 2, 1, 2};
    int nxt_lr[4] = '{0, 3, 0, 1};
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
        clr_cnt += int'(sw.clr);
        if (sw.go && sw.clr) overlap++;
    endtask
    task automatic press(input bit ss, input bit lr, input int hold);
        @(negedge clk);
        btn_ss = ss;
        btn_lr = lr;
        repeat (hold) step();
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (12) step();
    endtask
    task automatic glitch(input bit ss, input bit lr, input int n);
        @(negedge clk);
        btn_ss = ss;
        btn_lr = lr;
        repeat (n) @(negedge clk);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        repeat (12) step();
    endtask
    task automatic check_all(input string tag, input int st, input bit g, input bit lap,
                             input logic [23:0] disp, input int clrs);
        chk({tag, "_state"}, 32'(state), st);
        chk({tag, "_go"}, 32'(sw.go), 32'(g));
        chk({tag, "_lap_active"}, 32'(lap_active), 32'(lap));
        chk({tag, "_disp"}, 32'(disp_all), 32'(disp));
        chk({tag, "_clr_cycles"}, clr_cnt, clrs);
    endtask
    function automatic logic [23:0] rand_bcd();
        logic [23:0] r;
        for (int i = 0; i < 6; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction
    initial begin
        int m_state, k, exp_clr;
        logic [23:0] m_lap;
        bit e_ss, e_lr;
        vecs[0]  = '{1, 0, 24'h000000, 1, 1, 0, 24'h000000, 0};
        vecs[1]  = '{0, 1, 24'h012345, 3, 1, 1, 24'h012345, 0};
        vecs[2]  = '{0, 0, 24'h020000, 3, 1, 1, 24'h012345, 0};
        vecs[3]  = '{0, 1, 24'h020000, 1, 1, 0, 24'h020000, 0};
        vecs[4]  = '{1, 0, 24'h020000, 2, 0, 0, 24'h020000, 0};
        vecs[5]  = '{0, 1, 24'h456789, 0, 0, 0, 24'h456789, 1};
        vecs[6]  = '{1, 0, 24'h111111, 1, 1, 0, 24'h111111, 0};
        vecs[7]  = '{0, 1, 24'h111111, 3, 1, 1, 24'h111111, 0};
        vecs[8]  = '{1, 0, 24'h222222, 2, 0, 0, 24'h222222, 0};
        vecs[9]  = '{1, 0, 24'h333333, 1, 1, 0, 24'h333333, 0};
        vecs[10] = '{1, 1, 24'h444444, 2, 0, 0, 24'h444444, 0};
        vecs[11] = '{0, 1, 24'h555555, 0, 0, 0, 24'h555555, 1};
        vecs[12] = '{0, 1, 24'h666666, 0, 0, 0, 24'h666666, 0};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clr", 32'(sw.clr), 1);
        chk("rst_go", 32'(sw.go), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_disp", 32'(disp_all), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_exit_clr", 32'(sw.clr), 0);
        for (int i = 0; i < 13; i++) begin
            dv = vecs[i].d;
            clr_cnt = 0;
            if (vecs[i].ss || vecs[i].lr) press(vecs[i].ss, vecs[i].lr, 10);
            else repeat (3) step();
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].go, vecs[i].lap, vecs[i].disp, vecs[i].clrs);
        end
        @(negedge clk);
        btn_ss = 1'b1;
        repeat (6) step();
        chk("lat_go_early", 32'(sw.go), 0);
        step();
        chk("lat_go", 32'(sw.go), 1);
        chk("lat_state", 32'(state), 1);
        repeat (4) step();
        btn_ss = 1'b0;
        repeat (12) step();
        @(negedge clk);
        dv = 24'h987654;
        #1;
        chk("disp_hold", 32'(disp_all), 32'h666666);
        step();
        chk("disp_lag", 32'(disp_all), 32'h987654);
        glitch(1'b1, 1'b0, 3);
        chk("glitch_ss_state", 32'(state), 1);
        glitch(1'b0, 1'b1, 3);
        chk("glitch_lr_state", 32'(state), 1);
        foreach (vecs[i]) if (i < 4) begin
            @(negedge clk);
            btn_ss = (i % 2) == 1;
        end
        repeat (6) @(negedge clk);
        repeat (100) step();
        chk("bounce_state", 32'(state), 2);
        btn_ss = 1'b0;
        repeat (12) step();
        chk("bounce_release_state", 32'(state), 2);
        press(1'b1, 1'b0, 10);
        dv = 24'h135790;
        repeat (2) step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_clr", 32'(sw.clr), 1);
        chk("midrst_go", 32'(sw.go), 0);
        chk("midrst_disp", 32'(disp_all), 0);
        chk("midrst_state", 32'(state), 0);
        chk("midrst_lap_active", 32'(lap_active), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_clr_hold", 32'(sw.clr), 1);
        step();
        chk("midrst_exit_clr", 32'(sw.clr), 0);
        m_state = 0;
        m_lap = '0;
        for (int n = 0; n < 60; n++) begin
            dv = rand_bcd();
            k = $urandom_range(0, 5);
            e_ss = (k <= 1) || (k == 4);
            e_lr = (k == 2) || (k == 3) || (k == 4);
            clr_cnt = 0;
            if (k == 5) begin
                glitch($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, 3));
                e_ss = 1'b0;
                e_lr = 1'b0;
            end else begin
                press(e_ss, e_lr, $urandom_range(8, 20));
            end
            exp_clr = (e_lr && !e_ss && m_state == 2) ? 1 : 0;
            if (e_ss) m_state = nxt_ss[m_state];
            else if (e_lr) begin
                if (m_state == 1) m_lap = dv;
                m_state = nxt_lr[m_state];
            end
            check_all($sformatf("rand%0d", n), m_state, m_state == 1 || m_state == 3, m_state == 3,
                      m_state == 3 ? m_lap : dv, exp_clr);
        end
        chk("go_clr_exclusive", overlap, 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
